// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB-Lite constants and the default-slave state type
//                used by the address decoder and its default slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    // Transfer types carried on htrans
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Slave response encodings carried on hresp
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Upper bound on the number of decoded slave regions
    localparam int MAX_SLAVES = 16;

    // Default-slave response sequencer
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,   // zero-wait OKAY
        DS_ERR1 = 2'd1,   // first ERROR cycle, inserts a wait state
        DS_ERR2 = 2'd2    // second ERROR cycle, completes the transfer
    } ds_state_t;

    // A transfer only needs a response when it is NONSEQ or SEQ
    function automatic logic is_active_trans(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_default_slave
//  Description : Responder for accesses that miss every mapped region.
//                Active transfers get the two-cycle AHB ERROR response;
//                IDLE/BUSY transfers get a zero-wait OKAY. Each ERROR is
//                counted in a saturating counter.
//  Ports       : hclk, hresetn   - bus clock, async active-low reset
//                hready          - bus-level hready (transfer accepted)
//                no_hit          - address phase decodes to no slave
//                xfer_active     - address phase is NONSEQ or SEQ
//                hready_out      - default-slave hreadyout
//                hresp_out       - default-slave hresp
//                err_count       - saturating ERROR response count
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int ERRCNT_W = 16
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                hready,
    input  logic                no_hit,
    input  logic                xfer_active,
    output logic                hready_out,
    output logic                hresp_out,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic [ERRCNT_W-1:0] c_CNT_MAX = {ERRCNT_W{1'b1}};

    ds_state_t             r_state;
    ds_state_t             w_state_next;
    logic                  w_err_start;
    logic [ERRCNT_W-1:0]   r_err_count;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_start  = 1'b0;
        hready_out   = 1'b1;
        hresp_out    = HRESP_OKAY;
        case (r_state)
            DS_ERR1: begin
                hready_out   = 1'b0;
                hresp_out    = HRESP_ERROR;
                w_state_next = DS_ERR2;
            end
            DS_IDLE, DS_ERR2: begin
                // ERR2 completes the erroring transfer, so a new unmapped
                // active transfer can be accepted in the same cycle.
                hresp_out = (r_state == DS_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                if (hready && no_hit && xfer_active) begin
                    w_state_next = DS_ERR1;
                    w_err_start  = 1'b1;
                end else begin
                    w_state_next = DS_IDLE;
                end
            end
            default: begin
                w_state_next = DS_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_err_count <= '0;
        end else if (w_err_start && (r_err_count != c_CNT_MAX)) begin
            r_err_count <= r_err_count + ERRCNT_W'(1);
        end
    end

    assign err_count = r_err_count;

endmodule : ahb_default_slave
`default_nettype wire

// File: rtl/ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_addr_decoder
//  Description : AHB-Lite address decoder and slave-to-master response mux.
//                Decodes haddr against per-slave base/mask regions into a
//                one-hot hsel, registers the data-phase owner, and muxes the
//                owner's hrdata/hready/hresp back to the master. Unmapped
//                accesses are answered by an internal default slave.
//  Ports       : hclk, hresetn   - bus clock, async active-low reset
//                haddr, htrans   - master address phase
//                hsel            - one-hot address-phase slave select
//                hrdata_s        - packed slave read data
//                hready_s        - per-slave hreadyout
//                hresp_s         - per-slave hresp
//                hrdata          - muxed read data
//                hready          - muxed hready (also returned to slaves)
//                hresp           - muxed response
//                err_count       - default-slave ERROR count (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_addr_decoder
    import ahb_pkg::*;
#(
    parameter int                             NUM_SLAVES = 4,
    parameter int                             ADDR_W     = 32,
    parameter int                             DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE   = {32'h3000_0000, 32'h2000_0000,
                                                            32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_MASK   = {4{32'hF000_0000}},
    parameter int                             ERRCNT_W   = 16
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    output logic [NUM_SLAVES-1:0]        hsel,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    input  logic [NUM_SLAVES-1:0]        hready_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready,
    output logic                         hresp,
    output logic [ERRCNT_W-1:0]          err_count
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter guard
    // ------------------------------------------------------------------
    if ((NUM_SLAVES < 1) || (NUM_SLAVES > MAX_SLAVES)) begin : g_bad_num_slaves
        $error("ahb_addr_decoder: NUM_SLAVES must be in 1..16");
    end

    // Data-phase select is one bit wider than hsel; the top bit is the
    // default slave.
    localparam int                  c_DEF_IDX  = NUM_SLAVES;
    localparam logic [NUM_SLAVES:0] c_DSEL_RST = {1'b1, {NUM_SLAVES{1'b0}}};

    logic [NUM_SLAVES-1:0] w_hit;
    logic [NUM_SLAVES-1:0] w_hsel;
    logic                  w_hit_any;
    logic [NUM_SLAVES:0]   r_dsel;
    logic                  w_def_hready;
    logic                  w_def_hresp;
    logic [DATA_W-1:0]     w_hrdata;
    logic                  w_hready;
    logic                  w_hresp;
    logic                  w_xfer_active;

    // ------------------------------------------------------------------
    // Address decode: raw region hits, then lowest-index priority so
    // overlapping regions still produce a one-hot select.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
        assign w_hit[gi] = ((haddr & SLV_MASK[gi*ADDR_W +: ADDR_W])
                            == SLV_BASE[gi*ADDR_W +: ADDR_W]);
    end

    always_comb begin
        w_hsel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hsel    = '0;
                w_hsel[i] = 1'b1;
            end
        end
    end

    assign w_hit_any     = |w_hit;
    assign hsel          = w_hsel;
    assign w_xfer_active = is_active_trans(htrans);

    // ------------------------------------------------------------------
    // Data-phase owner: follows the decode only when the bus advances,
    // so a stalled data phase keeps its slave even if haddr moves on.
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_dsel <= c_DSEL_RST;
        end else if (w_hready) begin
            r_dsel <= {~w_hit_any, w_hsel};
        end
    end

    // ------------------------------------------------------------------
    // Response mux (AND-OR over the one-hot owner). The default slave
    // contributes no read data.
    // ------------------------------------------------------------------
    always_comb begin
        w_hrdata = '0;
        w_hready = 1'b0;
        w_hresp  = HRESP_OKAY;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_dsel[i]) begin
                w_hrdata = w_hrdata | hrdata_s[i*DATA_W +: DATA_W];
                w_hready = w_hready | hready_s[i];
                w_hresp  = w_hresp  | hresp_s[i];
            end
        end
        if (r_dsel[c_DEF_IDX]) begin
            w_hready = w_hready | w_def_hready;
            w_hresp  = w_hresp  | w_def_hresp;
        end
    end

    assign hrdata = w_hrdata;
    assign hready = w_hready;
    assign hresp  = w_hresp;

    // ------------------------------------------------------------------
    // Default slave
    // ------------------------------------------------------------------
    ahb_default_slave #(
        .ERRCNT_W    (ERRCNT_W)
    ) u_default_slave (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hready      (w_hready),
        .no_hit      (~w_hit_any),
        .xfer_active (w_xfer_active),
        .hready_out  (w_def_hready),
        .hresp_out   (w_def_hresp),
        .err_count   (err_count)
    );

endmodule : ahb_addr_decoder
`default_nettype wire
